// File: rtl/line_buffer_multi_if.sv
// Pixel stream in, primed vertical tap column out.
// master drives the pixel side; slave is the line buffer itself.
interface line_buffer_multi_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 64,
  parameter int LINES     = 2
);
  localparam int LEN_W = $clog2(MAX_DEPTH + 1);
  localparam int COL_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [LEN_W-1:0]           line_len;
  logic                       in_valid;
  logic                       in_sof;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic [(LINES+1)*WIDTH-1:0] out_taps;
  logic [COL_W-1:0]           out_col;
  logic                       out_eol;

  modport master (
    output line_len, in_valid, in_sof, in_data,
    input  out_valid, out_taps, out_col, out_eol
  );

  modport slave (
    input  line_len, in_valid, in_sof, in_data,
    output out_valid, out_taps, out_col, out_eol
  );
endinterface

// File: rtl/line_buffer_multi.sv
// Cascaded multi-line buffer: one pixel in, LINES+1 vertical taps out, 1-cycle latency.
// No backpressure; out_valid only once LINES full lines of the current frame are stored.
module line_buffer_multi #(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 64,
  parameter int LINES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  line_buffer_multi_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_DEPTH + 1);
  localparam int COL_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int FILL_W = $clog2(LINES + 1);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > LEN_W'(MAX_DEPTH)) return LEN_W'(MAX_DEPTH);
    return l;
  endfunction

  logic [COL_W-1:0]  col_q, cur_col, nxt_col;
  logic [LEN_W-1:0]  len_q, cur_len;
  logic [FILL_W-1:0] fill_q, cur_fill, nxt_fill;
  logic              at_end;

  logic [WIDTH-1:0]  mem [LINES][MAX_DEPTH];
  logic [WIDTH-1:0]  rd  [LINES];

  // An sof pixel behaves as column 0 of a fresh frame with a freshly latched length.
  always_comb begin
    cur_col  = bus.in_sof ? '0 : col_q;
    cur_len  = bus.in_sof ? clamp_len(bus.line_len) : len_q;
    cur_fill = bus.in_sof ? '0 : fill_q;
    at_end   = (LEN_W'(cur_col) == cur_len - LEN_W'(1));
    nxt_col  = at_end ? '0 : cur_col + COL_W'(1);
    nxt_fill = (at_end && cur_fill != FILL_W'(LINES)) ? cur_fill + FILL_W'(1) : cur_fill;
    for (int k = 0; k < LINES; k++) begin
      rd[k] = mem[k][cur_col];
    end
  end

  // Read-before-write: each bank shifts its old column value one bank deeper.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      mem[0][cur_col] <= bus.in_data;
      for (int k = 1; k < LINES; k++) begin
        mem[k][cur_col] <= rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      fill_q        <= '0;
      len_q         <= clamp_len(bus.line_len);
      bus.out_valid <= 1'b0;
      bus.out_taps  <= '0;
      bus.out_col   <= '0;
      bus.out_eol   <= 1'b0;
    end else if (bus.in_valid) begin
      col_q                   <= nxt_col;
      fill_q                  <= nxt_fill;
      len_q                   <= cur_len;
      bus.out_valid           <= (cur_fill == FILL_W'(LINES));
      bus.out_taps[WIDTH-1:0] <= bus.in_data;
      for (int k = 0; k < LINES; k++) begin
        bus.out_taps[(k+1)*WIDTH +: WIDTH] <= rd[k];
      end
      bus.out_col             <= cur_col;
      bus.out_eol             <= at_end;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_line_buffer_multi.sv
// Bench for line_buffer_multi: directed tables, corner sequences and a random stream
// checked against a frame-history model (pixel n of a frame sits at column n % len).
module tb_line_buffer_multi;
  localparam int W = 8;
  localparam int D = 64;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buffer_multi_if #(.WIDTH(W), .MAX_DEPTH(D), .LINES(L)) bus ();
  line_buffer_multi #(.WIDTH(W), .MAX_DEPTH(D), .LINES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_n;
  int         m_len;
  logic [7:0] hist[$];
  logic       m_valid;
  int         m_col;
  logic       m_eol;
  logic [7:0] m_tap[L+1];

  typedef struct {
    bit         v;
    bit         s;
    logic [7:0] d;
    bit         ev;
    int         ecol;
    bit         eeol;
    logic [7:0] et0, et1, et2;
  } vec_t;
  vec_t tbl[12];

  function automatic int clampi(int l);
    return (l == 0 || l > D) ? D : l;
  endfunction

  function automatic logic [7:0] tap(int k);
    return bus.out_taps[k*W +: W];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle(bit r, bit v, bit s, logic [7:0] d);
    rst = r; bus.in_valid = v; bus.in_sof = s; bus.in_data = d;
    @(posedge clk);
    if (r) begin
      m_n = 0; m_len = clampi(int'(bus.line_len)); hist.delete();
      m_valid = 0; m_col = 0; m_eol = 0;
      for (int k = 0; k <= L; k++) m_tap[k] = '0;
    end else if (v) begin
      if (s) begin
        m_n = 0; m_len = clampi(int'(bus.line_len)); hist.delete();
      end
      hist.push_back(d);
      m_col   = m_n % m_len;
      m_eol   = (m_col == m_len - 1);
      m_valid = (m_n / m_len) >= L;
      m_tap[0] = d;
      for (int k = 1; k <= L; k++)
        m_tap[k] = m_valid ? hist[m_n - k*m_len] : '0;
      m_n++;
    end else begin
      m_valid = 0;
    end
    #1;
    chk("model_valid", bus.out_valid, m_valid);
    if (r) begin
      chk("rst_taps", bus.out_taps, '0);
      chk("rst_col", bus.out_col, '0);
      chk("rst_eol", bus.out_eol, '0);
    end else if (v) begin
      chk("model_col", bus.out_col, m_col);
      chk("model_eol", bus.out_eol, m_eol);
      chk("model_tap0", tap(0), m_tap[0]);
    end
    if (m_valid)
      for (int k = 1; k <= L; k++) chk("model_tap", tap(k), m_tap[k]);
  endtask

  task automatic apply_vec(vec_t t);
    cycle(0, t.v, t.s, t.d);
    chk("tbl_valid", bus.out_valid, t.ev);
    chk("tbl_col", bus.out_col, t.ecol);
    chk("tbl_eol", bus.out_eol, t.eeol);
    if (t.ev) begin
      chk("tbl_tap0", tap(0), t.et0);
      chk("tbl_tap1", tap(1), t.et1);
      chk("tbl_tap2", tap(2), t.et2);
    end
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].v    = 1;
      tbl[i].s    = (i == 0);
      tbl[i].d    = 8'(i);
      tbl[i].ev   = (i >= 8);
      tbl[i].ecol = i % 4;
      tbl[i].eeol = (i % 4 == 3);
      tbl[i].et0  = 8'(i);
      tbl[i].et1  = 8'(i - 4);
      tbl[i].et2  = 8'(i - 8);
    end

    rst = 1; bus.in_valid = 0; bus.in_sof = 0; bus.in_data = '0;
    bus.line_len = 7'd4;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_taps", bus.out_taps, 0);

    // Priming, back-to-back
    for (int i = 0; i < 12; i++) apply_vec(tbl[i]);

    // Gapped: identical taps, nothing valid after idle cycles
    for (int i = 0; i < 12; i++) begin
      apply_vec(tbl[i]);
      cycle(0, 0, 0, 8'hEE);
      chk("gap_valid", bus.out_valid, 0);
      chk("gap_hold_tap0", tap(0), tbl[i].et0);
      chk("gap_hold_col", bus.out_col, tbl[i].ecol);
    end

    // Mid-line sof abandons the primed frame
    cycle(0, 1, 1, 8'd100);
    for (int i = 1; i < 10; i++) cycle(0, 1, 0, 8'(100 + i));
    for (int j = 0; j < 9; j++) begin
      cycle(0, 1, (j == 0), 8'(200 + j));
      chk("midsof_valid", bus.out_valid, (j == 8));
    end
    chk("midsof_tap0", tap(0), 8'd208);
    chk("midsof_tap1", tap(1), 8'd204);
    chk("midsof_tap2", tap(2), 8'd200);

    // Length 0 clamps to MAX_DEPTH
    bus.line_len = 7'd0;
    for (int i = 0; i < 66; i++) begin
      cycle(0, 1, (i == 0), 8'(i));
      if (i == 62) chk("clamp_eol62", bus.out_eol, 0);
      if (i == 63) begin
        chk("clamp_col63", bus.out_col, 63);
        chk("clamp_eol63", bus.out_eol, 1);
      end
      if (i == 64) chk("clamp_wrap", bus.out_col, 0);
    end

    // Single-pixel lines
    bus.line_len = 7'd1;
    cycle(0, 1, 1, 8'h11);
    chk("len1_v0", bus.out_valid, 0);
    cycle(0, 1, 0, 8'h22);
    chk("len1_v1", bus.out_valid, 0);
    cycle(0, 1, 0, 8'h33);
    chk("len1_v2", bus.out_valid, 1);
    chk("len1_col", bus.out_col, 0);
    chk("len1_taps", bus.out_taps, 24'h112233);

    // Reset during valid output; the pixel in the reset cycle is dropped
    bus.line_len = 7'd4;
    for (int i = 0; i < 10; i++) cycle(0, 1, (i == 0), 8'(50 + i));
    chk("pre_rst_valid", bus.out_valid, 1);
    cycle(1, 1, 0, 8'hAA);
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_taps", bus.out_taps, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, (i == 0), 8'(70 + i));
      chk("post_rst_valid", bus.out_valid, (i == 8));
    end

    // line_len change without sof is ignored until the next sof
    for (int i = 0; i < 3; i++) cycle(0, 1, (i == 0), 8'(i));
    bus.line_len = 7'd6;
    cycle(0, 1, 0, 8'd3);
    chk("lenchg_eol_old", bus.out_eol, 1);
    chk("lenchg_col_old", bus.out_col, 3);
    cycle(0, 1, 0, 8'd4);
    chk("lenchg_wrap_old", bus.out_col, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, (i == 0), 8'(i));
      if (i == 5) chk("lenchg_eol_new", bus.out_eol, 1);
      if (i == 6) chk("lenchg_wrap_new", bus.out_col, 0);
    end

    // Random stream against the model
    for (int c = 0; c < 4000; c++) begin
      bit r, v, s;
      r = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 79) == 0);
      if (r || s || $urandom_range(0, 9) == 0)
        bus.line_len = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(1, 8))
                                                   : 7'($urandom_range(0, 127));
      cycle(r, v, s, 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
